// File: rtl/vliw_ls_pkg.sv
// Shared types and helpers for the EU load/store arbiter.
package vliw_ls_pkg;

    typedef enum logic [1:0] {
        LS_BYTE = 2'd0,
        LS_HALF = 2'd1,
        LS_WORD = 2'd2
    } ls_size_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    // Right-aligned load data extended to 32 bits; size 3 behaves as word.
    function automatic logic [31:0] ls_extend(input logic [31:0] data,
                                              input logic [1:0]  size,
                                              input logic        sext);
        logic [31:0] r;
        case (size)
            LS_BYTE: r = {{24{sext & data[7]}}, data[7:0]};
            LS_HALF: r = {{16{sext & data[15]}}, data[15:0]};
            default: r = data;
        endcase
        return r;
    endfunction

    // Store data with bits above the transfer size forced to zero.
    function automatic logic [31:0] ls_mask(input logic [31:0] data,
                                            input logic [1:0]  size);
        logic [31:0] r;
        case (size)
            LS_BYTE: r = {24'b0, data[7:0]};
            LS_HALF: r = {16'b0, data[15:0]};
            default: r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: one-hot grant of the first active
// requester at or after ptr, wrapping past NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    logic found;
    int   idx;

    // Walk the requesters starting at the pointer, keep the first hit.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eu_loadstore_arbiter.sv
// Shares one memory data port between the EU load/store outputs.
// Round-robin grant, one transaction in flight, request fields latched at
// grant, load data extended per size and returned with the dest index.
// Optional build macro ARB_TIMEOUT_EN adds a bus wait limit and the err port.
module eu_loadstore_arbiter
    import vliw_ls_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = 32,
    parameter int IDX_W          = 6,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                             wb_clk_i,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req,
    input  logic [NUM_REQ-1:0]               req_we,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][1:0]          req_size,
    input  logic [NUM_REQ-1:0]               req_sext,
    input  logic [NUM_REQ-1:0][31:0]         req_wdata,
    input  logic [NUM_REQ-1:0][IDX_W-1:0]    req_dest,
    output logic [NUM_REQ-1:0]               done,
    output logic [31:0]                      rd_data,
    output logic [IDX_W-1:0]                 rd_dest,
    output logic                             rd_wen,
    output logic                             mem_req,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [1:0]                       mem_size,
    output logic [31:0]                      mem_wdata,
    input  logic                             mem_ready,
    input  logic [31:0]                      mem_rdata,
    output logic                             busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                             err
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        size;
        logic              sext;
        logic [31:0]       wdata;
        logic [IDX_W-1:0]  dest;
    } ls_req_t;

    arb_state_t         state, state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [NUM_REQ-1:0] grant, gnt_q;
    logic [PTR_W-1:0]   gnt_idx, gnt_idx_q;
    ls_req_t            sel, lreq;
    logic [31:0]        rdata_q;
    logic               err_q;
    logic               bus_ok;
    logic               bus_tmo;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] wait_cnt;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (grant)
    );

    // Mux the granted requester's fields; store data is masked here so the
    // latched copy is already bus-ready.
    always_comb begin
        sel     = '0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx    = PTR_W'(i);
                sel.we     = req_we[i];
                sel.addr   = req_addr[i];
                sel.size   = req_size[i];
                sel.sext   = req_sext[i];
                sel.wdata  = ls_mask(req_wdata[i], req_size[i]);
                sel.dest   = req_dest[i];
            end
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) state <= ARB_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: a response always takes one RESP cycle before re-arbitrating.
    always_comb begin
        state_nxt = state;
        bus_ok    = 1'b0;
        bus_tmo   = 1'b0;
        case (state)
            ARB_IDLE: if (|req) state_nxt = ARB_BUS;
            ARB_BUS: begin
                if (mem_ready) begin
                    bus_ok    = 1'b1;
                    state_nxt = ARB_RESP;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wait_cnt == TMO_LAST) begin
                    bus_tmo   = 1'b1;
                    state_nxt = ARB_RESP;
                end
`endif
            end
            ARB_RESP: state_nxt = ARB_IDLE;
            default:  state_nxt = ARB_IDLE;
        endcase
    end

    // Latch the grant in IDLE, capture the response in BUS, advance the
    // round-robin pointer past the winner in RESP.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            lreq      <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: if (|req) begin
                    gnt_q     <= grant;
                    gnt_idx_q <= gnt_idx;
                    lreq      <= sel;
                end
                ARB_BUS: begin
                    if (bus_ok) begin
                        rdata_q <= lreq.we ? 32'b0 : ls_extend(mem_rdata, lreq.size, lreq.sext);
                        err_q   <= 1'b0;
                    end else if (bus_tmo) begin
                        rdata_q <= 32'b0;
                        err_q   <= 1'b1;
                    end
                end
                ARB_RESP: ptr <= (gnt_idx_q == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
                default: ;
            endcase
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Bus wait counter: zero on BUS entry, counts every BUS cycle.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n)                 wait_cnt <= '0;
        else if (state == ARB_BUS)  wait_cnt <= wait_cnt + 8'd1;
        else                        wait_cnt <= '0;
    end

    assign err = (state == ARB_RESP) & err_q;
`endif

    // Outputs decode from state so an async reset zeroes them at once.
    always_comb begin
        busy      = (state != ARB_IDLE);
        mem_req   = (state == ARB_BUS);
        mem_we    = mem_req & lreq.we;
        mem_addr  = mem_req ? lreq.addr : '0;
        mem_size  = mem_req ? lreq.size : 2'b0;
        mem_wdata = mem_we ? lreq.wdata : 32'b0;
        done      = (state == ARB_RESP) ? gnt_q : '0;
        rd_data   = (state == ARB_RESP) ? rdata_q : 32'b0;
        rd_dest   = (state == ARB_RESP) ? lreq.dest : '0;
        rd_wen    = (state == ARB_RESP) & ~lreq.we & ~err_q;
    end

endmodule

// File: tb/tb_eu_loadstore_arbiter.sv
// Scoreboard bench for eu_loadstore_arbiter: random EU drivers, a bus
// responder that predicts each response, and directed corner cases.
module tb_eu_loadstore_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO = 4;
`else
    localparam int TMO = 255;
`endif

    logic        wb_clk_i = 1'b0;
    logic        rst_n    = 1'b0;
    logic [2:0]  req, req_we, req_sext;
    logic [95:0] req_addr, req_wdata;
    logic [5:0]  req_size;
    logic [17:0] req_dest;
    logic [2:0]  done;
    logic [31:0] rd_data;
    logic [5:0]  rd_dest;
    logic        rd_wen, mem_req, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'b0;
`ifdef ARB_TIMEOUT_EN
    logic        err;
`endif

    logic        eu_req [3];
    logic        eu_we  [3];
    logic [31:0] eu_addr[3];
    logic [1:0]  eu_size[3];
    logic        eu_sext[3];
    logic [31:0] eu_wdata[3];
    logic [5:0]  eu_dest[3];

    assign req       = {eu_req[2],   eu_req[1],   eu_req[0]};
    assign req_we    = {eu_we[2],    eu_we[1],    eu_we[0]};
    assign req_sext  = {eu_sext[2],  eu_sext[1],  eu_sext[0]};
    assign req_addr  = {eu_addr[2],  eu_addr[1],  eu_addr[0]};
    assign req_wdata = {eu_wdata[2], eu_wdata[1], eu_wdata[0]};
    assign req_size  = {eu_size[2],  eu_size[1],  eu_size[0]};
    assign req_dest  = {eu_dest[2],  eu_dest[1],  eu_dest[0]};

    eu_loadstore_arbiter #(
        .NUM_REQ(3), .ADDR_W(32), .IDX_W(6), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .wb_clk_i (wb_clk_i), .rst_n (rst_n),
        .req (req), .req_we (req_we), .req_addr (req_addr), .req_size (req_size),
        .req_sext (req_sext), .req_wdata (req_wdata), .req_dest (req_dest),
        .done (done), .rd_data (rd_data), .rd_dest (rd_dest), .rd_wen (rd_wen),
        .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr), .mem_size (mem_size),
        .mem_wdata (mem_wdata), .mem_ready (mem_ready), .mem_rdata (mem_rdata),
        .busy (busy)
`ifdef ARB_TIMEOUT_EN
        , .err (err)
`endif
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  done;
        logic        we;
        logic [31:0] data;
        logic [5:0]  dest;
    } exp_t;

    exp_t exp_q[$];
    int   gnt_log[$];
    logic mon_en = 1'b0;

    // Reference: size/sign handling done with integer arithmetic.
    function automatic logic [31:0] exp_ext(input logic [31:0] d, input logic [1:0] sz, input logic sx);
        int v;
        if (sz == 2'd0) begin
            v = int'(d % 256);
            if (sx && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = int'(d % 65536);
            if (sx && v >= 32768) v = v - 65536;
        end else begin
            return d;
        end
        return 32'(v);
    endfunction

    function automatic logic [31:0] exp_mask(input logic [31:0] d, input logic [1:0] sz);
        if (sz == 2'd0) return d % 256;
        if (sz == 2'd1) return d % 65536;
        return d;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk_i);
        #1;
    endtask

    // One EU: raise a random request, hold it until done, drop it for at
    // least one cycle, optionally idle a few more.
    task automatic run_eu(input int i, input int n, input int max_gap);
        for (int t = 0; t < n; t++) begin
            int cyc;
            eu_we[i]    = 1'($urandom_range(1, 0));
            eu_addr[i]  = $urandom;
            eu_size[i]  = 2'($urandom_range(3, 0));
            eu_sext[i]  = 1'($urandom_range(1, 0));
            eu_wdata[i] = $urandom;
            eu_dest[i]  = 6'($urandom_range(63, 0));
            eu_req[i]   = 1'b1;
            cyc = 0;
            do begin
                tick();
                cyc++;
            end while (!done[i] && cyc < 300);
            if (!done[i]) chk($sformatf("eu%0d_done_timeout", i), 32'(done[i]), 32'd1);
            tick();
            eu_req[i] = 1'b0;
            tick();
            repeat ($urandom_range(max_gap, 0)) tick();
        end
    endtask

    // Monitor, arbitration model and bus responder (all on the falling edge).
    int          model_ptr = 0;
    int          delay = 0;
    int          cur = 0;
    logic        rdy_prev = 1'b0;
    logic        mreq_prev = 1'b0;
    logic        snap_req[3];
    logic        snap_we[3];
    logic [31:0] snap_addr[3];
    logic [1:0]  snap_size[3];
    logic        snap_sext[3];
    logic [31:0] snap_wdata[3];
    logic [5:0]  snap_dest[3];
    logic        cur_we, cur_sext;
    logic [1:0]  cur_size;
    logic [5:0]  cur_dest;

    always @(negedge wb_clk_i) begin
        if (mon_en) begin
            if (rdy_prev) begin
                if (exp_q.size() == 0) begin
                    chk("sb_queue_empty", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb_done", 32'(done), 32'(e.done));
                    chk("sb_rd_data", rd_data, e.data);
                    chk("sb_rd_wen", 32'(rd_wen), 32'(!e.we));
                    if (!e.we) chk("sb_rd_dest", 32'(rd_dest), 32'(e.dest));
`ifdef ARB_TIMEOUT_EN
                    chk("sb_err", 32'(err), 32'd0);
`endif
                end
            end else if (done != 3'b0) begin
                chk("sb_unexpected_done", 32'(done), 32'd0);
            end

            if (mem_req && !mreq_prev) begin
                int w;
                w = -1;
                for (int k = 0; k < 3; k++) begin
                    int j;
                    j = (model_ptr + k) % 3;
                    if (w < 0 && snap_req[j]) w = j;
                end
                if (w < 0) begin
                    chk("sb_grant_without_req", 32'(mem_req), 32'd0);
                end else begin
                    cur = w;
                    model_ptr = (w + 1) % 3;
                    gnt_log.push_back(w);
                    delay = $urandom_range(3, 0);
                    cur_we = snap_we[w]; cur_size = snap_size[w];
                    cur_sext = snap_sext[w]; cur_dest = snap_dest[w];
                    chk("sb_mem_we", 32'(mem_we), 32'(snap_we[w]));
                    chk("sb_mem_addr", mem_addr, snap_addr[w]);
                    chk("sb_mem_size", 32'(mem_size), 32'(snap_size[w]));
                    if (snap_we[w]) chk("sb_mem_wdata", mem_wdata, exp_mask(snap_wdata[w], snap_size[w]));
                end
            end

            rdy_prev = 1'b0;
            if (mem_req) begin
                if (delay == 0) begin
                    exp_t e;
                    mem_ready = 1'b1;
                    mem_rdata = $urandom;
                    e.done = 3'(1 << cur);
                    e.we   = cur_we;
                    e.data = cur_we ? 32'b0 : exp_ext(mem_rdata, cur_size, cur_sext);
                    e.dest = cur_dest;
                    exp_q.push_back(e);
                    rdy_prev = 1'b1;
                end else begin
                    mem_ready = 1'b0;
                    delay--;
                end
            end else begin
                mem_ready = 1'b0;
            end

            mreq_prev = mem_req;
            for (int k = 0; k < 3; k++) begin
                snap_req[k] = eu_req[k];   snap_we[k]    = eu_we[k];
                snap_addr[k] = eu_addr[k]; snap_size[k]  = eu_size[k];
                snap_sext[k] = eu_sext[k]; snap_wdata[k] = eu_wdata[k];
                snap_dest[k] = eu_dest[k];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            eu_req[k] = 1'b0; eu_we[k] = 1'b0; eu_addr[k] = 32'b0; eu_size[k] = 2'b0;
            eu_sext[k] = 1'b0; eu_wdata[k] = 32'b0; eu_dest[k] = 6'b0;
            snap_req[k] = 1'b0;
        end
        #3;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_wen", 32'(rd_wen), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);

        // All three requesting out of reset: strict EU0, EU1, EU2 order.
        mon_en = 1'b1;
        gnt_log.delete();
        fork
            run_eu(0, 1, 0);
            run_eu(1, 1, 0);
            run_eu(2, 1, 0);
            begin tick(); rst_n = 1'b1; end
        join
        chk("order_count", 32'(gnt_log.size()), 32'd3);
        for (int k = 0; k < 3 && k < gnt_log.size(); k++)
            chk($sformatf("order_%0d", k), 32'(gnt_log[k]), 32'(k));

        // EU0 keeps coming back while EU2 waits: EU2 goes second.
        gnt_log.delete();
        fork
            run_eu(0, 3, 0);
            run_eu(2, 1, 0);
        join
        chk("fair_count", 32'(gnt_log.size()), 32'd4);
        if (gnt_log.size() >= 2) begin
            chk("fair_first", 32'(gnt_log[0]), 32'd0);
            chk("fair_eu2_second", 32'(gnt_log[1]), 32'd2);
        end

        // Random traffic from all EUs.
        fork
            run_eu(0, 12, 3);
            run_eu(1, 12, 3);
            run_eu(2, 12, 3);
        join
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        mem_ready = 1'b0;

        // Directed cases from a clean reset.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();

        // Store, EU2, half word.
        eu_we[2] = 1'b1; eu_size[2] = 2'd1; eu_wdata[2] = 32'hDEADBEEF;
        eu_addr[2] = 32'h200; eu_req[2] = 1'b1;
        tick();
        chk("st_mem_req", 32'(mem_req), 32'd1);
        chk("st_mem_we", 32'(mem_we), 32'd1);
        chk("st_mem_wdata", mem_wdata, 32'h0000BEEF);
        chk("st_mem_size", 32'(mem_size), 32'd1);
        mem_ready = 1'b1;
        tick();
        chk("st_done", 32'(done), 32'b100);
        chk("st_rd_wen", 32'(rd_wen), 32'd0);
        chk("st_rd_data", rd_data, 32'd0);
        eu_req[2] = 1'b0; mem_ready = 1'b0;
        tick();
        chk("st_idle", 32'(busy), 32'd0);

        // Load, EU1, signed byte, ready on the second bus cycle.
        eu_we[1] = 1'b0; eu_addr[1] = 32'h100; eu_size[1] = 2'd0; eu_sext[1] = 1'b1;
        eu_dest[1] = 6'd37; eu_req[1] = 1'b1;
        tick();
        chk("ld_mem_addr", mem_addr, 32'h100);
        chk("ld_mem_we", 32'(mem_we), 32'd0);
        tick();
        chk("ld_wait_req", 32'(mem_req), 32'd1);
        chk("ld_wait_done", 32'(done), 32'd0);
        mem_ready = 1'b1; mem_rdata = 32'h000000F3;
        tick();
        chk("ld_done", 32'(done), 32'b010);
        chk("ld_rd_data", rd_data, 32'hFFFFFFF3);
        chk("ld_rd_dest", 32'(rd_dest), 32'd37);
        chk("ld_rd_wen", 32'(rd_wen), 32'd1);
        eu_req[1] = 1'b0; mem_ready = 1'b0;
        tick();

        // Reset while on the bus (pointer is 2 here), then all request.
        eu_req[2] = 1'b1;
        tick();
        chk("rb_mem_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rb_mem_req_off", 32'(mem_req), 32'd0);
        chk("rb_busy_off", 32'(busy), 32'd0);
        chk("rb_mem_addr_off", mem_addr, 32'd0);
        eu_req[2] = 1'b0;
        @(negedge wb_clk_i);
        chk("rb_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick();
        eu_we[0] = 1'b0; eu_addr[0] = 32'h300; eu_size[0] = 2'd1; eu_sext[0] = 1'b0;
        eu_req[0] = 1'b1; eu_req[1] = 1'b1; eu_req[2] = 1'b1;
        tick();
        chk("rb_fresh_addr", mem_addr, 32'h300);
        mem_ready = 1'b1; mem_rdata = 32'h12348080;
        tick();
        chk("rb_fresh_done", 32'(done), 32'b001);
        chk("rb_fresh_data", rd_data, 32'h00008080);
        eu_req[0] = 1'b0; eu_req[1] = 1'b0; eu_req[2] = 1'b0; mem_ready = 1'b0;
        tick();

`ifdef ARB_TIMEOUT_EN
        // Bus never answers: give up after four bus cycles.
        eu_we[0] = 1'b0; eu_req[0] = 1'b1;
        repeat (4) tick();
        chk("to_still_waiting", 32'(mem_req), 32'd1);
        tick();
        chk("to_done", 32'(done), 32'b001);
        chk("to_err", 32'(err), 32'd1);
        chk("to_rd_wen", 32'(rd_wen), 32'd0);
        chk("to_rd_data", rd_data, 32'd0);
        chk("to_mem_req", 32'(mem_req), 32'd0);
        eu_req[0] = 1'b0;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
